// File: rtl/counter_pkg.sv
// ============================================================================
// Module  : counter_pkg
// Brief   : Mode and direction encodings shared by the up/down counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
endpackage

`default_nettype wire

// File: rtl/mod_updown_counter.sv
// ============================================================================
// Module  : mod_updown_counter
// Brief   : N-bit up/down counter with runtime bound, wrap/saturate modes,
//           combinational terminal count and registered boundary pulses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         up_down,
    input  logic         sat_mode,
    input  logic [N-1:0] max_val,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         ovf,
    output logic         unf
);

    localparam logic [N-1:0] c_ZERO = '0;
    localparam logic [N-1:0] c_ONE  = N'(1);

    logic [N-1:0] count_q, count_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;
    logic [N-1:0] w_load_clamped;

    assign w_load_clamped = (load_val > max_val) ? max_val : load_val;

    // Boundaries are tested before the +/-1 so no N-bit overflow can occur.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (clr) begin
            count_d = c_ZERO;
        end else if (load) begin
            count_d = w_load_clamped;
        end else if (en) begin
            if (up_down == DIR_UP) begin
                if (count_q >= max_val) begin
                    ovf_d   = 1'b1;
                    count_d = (sat_mode == MODE_SAT) ? max_val : c_ZERO;
                end else begin
                    count_d = count_q + c_ONE;
                end
            end else begin
                if (count_q == c_ZERO) begin
                    unf_d   = 1'b1;
                    count_d = (sat_mode == MODE_SAT) ? c_ZERO : max_val;
                end else if (count_q > max_val) begin
                    // Bound was lowered under us: snap back into range silently.
                    count_d = max_val;
                end else begin
                    count_d = count_q - c_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= c_ZERO;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign tc    = (up_down == DIR_UP) ? (count_q >= max_val) : (count_q == c_ZERO);

endmodule

`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
// ============================================================================
// Module  : tb_mod_updown_counter
// Brief   : Scoreboard bench for mod_updown_counter at N = 4.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_updown_counter;
    localparam int N = 4;

    typedef struct {
        logic [N-1:0] cnt;
        logic         ovf;
        logic         unf;
        logic         tc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0, clr = 1'b0, load = 1'b0, en = 1'b0;
    logic         up_down = 1'b1, sat_mode = 1'b0;
    logic [N-1:0] load_val = '0, max_val = '0;
    logic [N-1:0] count;
    logic         tc, ovf, unf;

    int   n_checks = 0;
    int   n_errors = 0;
    int   m_cnt    = 0;
    exp_t sb_q[$];

    mod_updown_counter #(.N(N)) dut (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_down(up_down), .sat_mode(sat_mode), .max_val(max_val),
        .count(count), .tc(tc), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, predict the outcome, then compare after the edge.
    task automatic cyc(input logic r, input logic c, input logic l, input int lv,
                       input logic e, input logic ud, input logic sm, input int mx);
        exp_t x;
        int   nxt;
        @(negedge clk);
        rst = r; clr = c; load = l; load_val = lv[N-1:0];
        en = e; up_down = ud; sat_mode = sm; max_val = mx[N-1:0];
        x.ovf = 1'b0;
        x.unf = 1'b0;
        nxt   = m_cnt;
        if (r)      nxt = 0;
        else if (c) nxt = 0;
        else if (l) nxt = (lv < mx) ? lv : mx;
        else if (e && ud) begin
            if (m_cnt < mx) nxt = m_cnt + 1;
            else begin x.ovf = 1'b1; nxt = sm ? mx : 0; end
        end else if (e) begin
            if (m_cnt == 0) begin x.unf = 1'b1; nxt = sm ? 0 : mx; end
            else if (m_cnt > mx) nxt = mx;
            else nxt = m_cnt - 1;
        end
        m_cnt = nxt;
        x.cnt = nxt[N-1:0];
        x.tc  = ud ? (nxt >= mx) : (nxt == 0);
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            x = sb_q.pop_front();
            chk("count", 32'(count), 32'(x.cnt));
            chk("ovf",   32'(ovf),   32'(x.ovf));
            chk("unf",   32'(unf),   32'(x.unf));
            chk("tc",    32'(tc),    32'(x.tc));
            chk("excl",  32'(ovf & unf), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int seq_dn[7]  = '{4, 3, 2, 1, 0, 5, 4};
        int n_pulse;

        // Reset, then wrap-mode up count to 9
        cyc(1, 0, 0, 0, 0, 1, 0, 9);
        cyc(1, 0, 0, 0, 0, 1, 0, 9);
        chk("rst_count", 32'(count), 0);
        n_pulse = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0, 0, 1, 1, 0, 9);
            chk("up_seq", 32'(count), 32'(seq_up[i]));
            n_pulse += int'(ovf);
        end
        chk("up_ovf_pulses", 32'(n_pulse), 1);

        // Saturate at both ends
        cyc(0, 0, 1, 14, 0, 1, 1, 15);
        n_pulse = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1, 1, 1, 15);
            chk("sat_hi", 32'(count), 15);
            n_pulse += int'(ovf);
        end
        chk("sat_ovf_pulses", 32'(n_pulse), 2);
        cyc(0, 0, 1, 1, 0, 0, 1, 15);
        n_pulse = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1, 0, 1, 15);
            chk("sat_lo", 32'(count), 0);
            n_pulse += int'(unf);
        end
        chk("sat_unf_pulses", 32'(n_pulse), 2);

        // Clamped load then down-wrap
        cyc(0, 0, 1, 12, 0, 0, 0, 5);
        chk("clamp_load", 32'(count), 5);
        n_pulse = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, 0, 1, 0, 0, 5);
            chk("dn_seq", 32'(count), 32'(seq_dn[i]));
            n_pulse += int'(unf);
        end
        chk("dn_unf_pulses", 32'(n_pulse), 1);

        // Priority
        cyc(0, 0, 1, 7, 0, 1, 0, 15);
        cyc(0, 1, 1, 9, 1, 1, 0, 15);
        chk("prio_clr", 32'(count), 0);
        cyc(0, 0, 1, 3, 1, 1, 0, 15);
        chk("prio_load", 32'(count), 3);

        // Lowered bound, then reset during the ovf pulse
        cyc(0, 0, 1, 12, 0, 0, 0, 15);
        cyc(0, 0, 0, 0, 1, 0, 0, 6);
        chk("lowered_dn", 32'(count), 6);
        cyc(0, 0, 0, 0, 1, 1, 0, 6);
        chk("lowered_up_ovf", 32'(ovf), 1);
        cyc(1, 0, 0, 0, 1, 1, 0, 6);
        chk("rst_kills_ovf", 32'(ovf), 0);
        cyc(0, 0, 0, 0, 1, 1, 0, 6);
        chk("after_rst_step", 32'(count), 1);

        // Degenerate bound
        cyc(1, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1, 1, 1, 0);
            chk("mx0_ovf", 32'(ovf), 1);
        end
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("mx0_unf", 32'(unf), 1);

        // Random mix checked against the scoreboard model
        for (int i = 0; i < 200; i++) begin
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
                1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
